rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the register file (NREG instances of the synchronous-reset, write-enabled W-bit register) among NREQ requesters.
- Round-robin arbitration, valid/ack handshake, and a bulk-clear command that drives every register's synchronous reset.
- Sits between the execute/writeback sources and the register file. All per-register enables and resets come from this block.

Parameters:
- W, 8, data width of each register.
- NREQ, 4, number of write requesters (2..8).
- NREG, 16, number of registers in the file.
- AW, 4, address width; NREG <= 2^AW.

Ports:
- clk  input  1  rising-edge clock.
- reset_synchronous  input  1  synchronous active-high reset, sampled on posedge clk.
- req_valid  input  NREQ  per-requester write request; held until acked.
- req_addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*W  packed data; requester i uses bits [i*W +: W].
- req_ack  output  NREQ  one-cycle ack pulse, at most one bit set.
- req_err  output  1  high with req_ack when the acked address >= NREG.
- clear_req  input  1  request to clear the whole register file.
- rf_write_enable  output  NREG  one-hot (or zero) write enable to the registers.
- rf_reset  output  NREG  per-register synchronous reset.
- rf_data  output  W  shared write data to all registers.
- busy  output  1  high while a clear is pending or executing.

Behaviour:
- All outputs are registered.
- Reset (reset_synchronous=1 at posedge), applied regardless of any other input:
  - req_ack=0, req_err=0, rf_write_enable=0, rf_reset=0, rf_data=0, busy=0.
  - Round-robin pointer=0, FSM=IDLE, clear_pending=0.
- FSM states: IDLE, CLEAR.
- IDLE, at each posedge:
  - If clear_pending or clear_req: go to CLEAR. Drive rf_reset = all ones for the next cycle, busy=1, and make no grant this cycle.
  - Otherwise choose the winner among eligible requesters. Eligible means req_valid[i]=1 and req_ack[i]=0 (the current ack output). The search starts at the pointer and goes upward, wrapping at NREQ.
  - With winner i, in the next cycle:
    - req_ack[i]=1 and rf_data=req_data[i].
    - If addr < NREG: rf_write_enable[addr]=1.
    - If addr >= NREG: rf_write_enable=0 and req_err=1.
    - Pointer becomes (i+1) mod NREQ.
  - With no winner: ack, err and enable are all 0. rf_data holds its last value. Pointer is unchanged.
- Latency: request to ack/enable is 1 cycle. The register captures data on the following edge, so data is visible at the register output 2 cycles after the request is sampled.
- Throughput: one write per cycle across requesters. A single requester gets at most one grant every 2 cycles, because of the ack exclusion.
- Requester protocol: keep valid/addr/data stable until the ack is seen, then deassert or present a new request. Valid still high on the ack cycle is not regranted.
- CLEAR:
  - Lasts exactly 1 cycle: rf_reset = all ones, rf_write_enable = 0, busy=1.
  - Then return to IDLE with clear_pending=0. busy=0 on the following cycle unless clear_req is high again.
- clear_req arriving while in CLEAR: sets clear_pending, giving a back-to-back CLEAR.
- clear_req arriving in the same cycle as valid requests: clear wins. Requests stay pending and are granted after CLEAR. The pointer is not advanced.
- rf_reset and rf_write_enable are never both nonzero in the same cycle.
- Reset during CLEAR or mid-handshake: everything returns to reset values immediately. Requesters must re-present.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins. The pointer is held at 0 and never updates. The ack-exclusion rule still applies.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then req_valid=4'b0001, addr 3, data 8'hA5 → next cycle req_ack=4'b0001, rf_write_enable=16'h0008, rf_data=8'hA5. Register 3 reads 8'hA5 one cycle later.
- All four requesters held valid, each with a distinct addr/data, pointer=0 → acks in order 0,1,2,3 on consecutive cycles. Each write lands at the correct address. No requester is acked twice while the others wait.
- Requester 2, addr 4'd15, with NREG=12 → req_ack[2]=1, req_err=1, rf_write_enable=0. No register changes.
- clear_req together with req_valid=4'b0010 → next cycle rf_reset=16'hFFFF, busy=1, no ack. Cycle after: ack[1] plus its write. All other registers read 0.
- Reset asserted in the cycle after a grant, with valid still high → outputs 0 and pointer 0. The re-grant happens only after reset is released.
- With ARB_FIXED_PRIORITY_EN defined, requesters 0 and 3 held valid → 0 is acked every other cycle; 3 is acked only in the gap cycles.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter for the register file, with a bulk-clear command.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins).
module rf_write_arbiter #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic               clk,
  input  logic               reset_synchronous,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*W-1:0]  req_data,
  output logic [NREQ-1:0]    req_ack,
  output logic               req_err,
  input  logic               clear_req,
  output logic [NREG-1:0]    rf_write_enable,
  output logic [NREG-1:0]    rf_reset,
  output logic [W-1:0]       rf_data,
  output logic               busy,
  output logic               dbg_state
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  // Handshake: a requester holds req_valid/addr/data stable until it sees its
  // one-cycle req_ack; a valid still high during its own ack cycle is not regranted.

  state_t          state;
  logic            clear_pending;
  logic [PW-1:0]   ptr;

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [PW-1:0]   win;
  logic [AW-1:0]   win_addr;
  logic [W-1:0]    win_data;
  logic            addr_ok;
  logic [NREG-1:0] win_we;
  logic            do_grant;

  always_comb begin
    int idx;
    idx      = 0;
    eligible = req_valid & ~req_ack;
    found    = 1'b0;
    win      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    win_addr = req_addr[int'(win)*AW +: AW];
    win_data = req_data[int'(win)*W +: W];
    addr_ok  = 32'(win_addr) < NREG;
    win_we   = addr_ok ? (NREG'(1) << win_addr) : '0;
  end

  // The edge that ends CLEAR may already grant, unless another clear is asked for.
  always_comb begin
    if (state == IDLE) do_grant = !(clear_pending || clear_req);
    else               do_grant = !clear_req;
  end

`ifndef ARB_FIXED_PRIORITY_EN
  logic [PW-1:0] nxt_ptr;
  always_comb begin
    nxt_ptr = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_synchronous) begin
      state           <= IDLE;
      clear_pending   <= 1'b0;
      ptr             <= '0;
      req_ack         <= '0;
      req_err         <= 1'b0;
      rf_write_enable <= '0;
      rf_reset        <= '0;
      rf_data         <= '0;
      busy            <= 1'b0;
    end else begin
      req_ack         <= '0;
      req_err         <= 1'b0;
      rf_write_enable <= '0;
      rf_reset        <= '0;
      case (state)
        IDLE: begin
          if (clear_pending || clear_req) begin
            state         <= CLEAR;
            rf_reset      <= '1;
            busy          <= 1'b1;
            clear_pending <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          state         <= IDLE;
          busy          <= clear_req;
          clear_pending <= clear_req;
        end
        default: state <= IDLE;
      endcase
      if (do_grant && found) begin
        req_ack         <= NREQ'(1) << win;
        req_err         <= !addr_ok;
        rf_write_enable <= win_we;
        rf_data         <= win_data;
`ifdef ARB_FIXED_PRIORITY_EN
        ptr             <= '0;
`else
        ptr             <= nxt_ptr;
`endif
      end
    end
  end

  assign dbg_state = (state == CLEAR);

endmodule
